// File: rtl/inst_queue.sv
// Four-wide instruction buffer between fetch and decode: a DEPTH-entry ring that
// accepts 0-4 sequential slots per cycle and presents the four oldest to decode.
module inst_queue #(
   parameter int DEPTH = 16,
   parameter int IW    = 32,
   parameter int AW    = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     stallD,
   input  logic [2:0]               push_cnt,
   input  logic [4*AW-1:0]          push_pc,
   input  logic [4*IW-1:0]          push_instr,
   output logic                     push_ready,
   input  logic [2:0]               pop_cnt,
   output logic [3:0]               out_valid,
   output logic [4*AW-1:0]          out_pc,
   output logic [4*IW-1:0]          out_instr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [2:0]    push_lim;
   logic [CW-1:0] push_eff, pop_req, pop_eff;
   logic [3:0]    wr_en;

   logic [AW-1:0] pc_mem_q    [DEPTH];
   logic [IW-1:0] instr_mem_q [DEPTH];

   // Readiness looks only at the registered count, so no path from pop_cnt to stallF.
   assign push_ready = (CW'(DEPTH) - count_q) >= CW'(4);

   always_comb begin
      push_lim   = (push_cnt > 3'd4) ? 3'd4 : push_cnt;
      push_eff   = push_ready ? CW'(push_lim) : '0;
      pop_req    = CW'(pop_cnt);
      pop_eff    = stallD ? '0 : ((pop_req > count_q) ? count_q : pop_req);
      overflow_d = overflow_q | ((push_cnt != 3'd0) & ~push_ready);
      head_d     = head_q + PW'(pop_eff);
      tail_d     = tail_q + PW'(push_eff);
      count_d    = count_q - pop_eff + push_eff;
      for (int i = 0; i < 4; i++) wr_en[i] = ~flush & (CW'(i) < push_eff);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset; lanes are masked by out_valid until written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i]) begin
            pc_mem_q[tail_q + PW'(i)]    <= push_pc[i*AW +: AW];
            instr_mem_q[tail_q + PW'(i)] <= push_instr[i*IW +: IW];
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_lane
      assign out_valid[g]         = count_q > CW'(g);
      assign out_pc[g*AW +: AW]    = out_valid[g] ? pc_mem_q[head_q + PW'(g)]    : '0;
      assign out_instr[g*IW +: IW] = out_valid[g] ? instr_mem_q[head_q + PW'(g)] : '0;
   end

   assign count        = count_q;
   assign overflow_err = overflow_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, push/pop, full refusal, stall, flush and ring wrap.
module tb_inst_queue;
   localparam int DEPTH = 16;
   localparam int IW    = 32;
   localparam int AW    = 32;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            flush = 1'b0;
   logic            stallD = 1'b0;
   logic [2:0]      push_cnt = '0;
   logic [2:0]      pop_cnt = '0;
   logic [4*AW-1:0] push_pc = '0;
   logic [4*IW-1:0] push_instr = '0;
   logic            push_ready;
   logic [3:0]      out_valid;
   logic [4*AW-1:0] out_pc;
   logic [4*IW-1:0] out_instr;
   logic [4:0]      count;
   logic            overflow_err;

   int passes = 0;
   int total  = 0;

   inst_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .stallD(stallD),
      .push_cnt(push_cnt), .push_pc(push_pc), .push_instr(push_instr),
      .push_ready(push_ready), .pop_cnt(pop_cnt), .out_valid(out_valid),
      .out_pc(out_pc), .out_instr(out_instr), .count(count),
      .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [AW-1:0] lpc(input int i);
      return out_pc[i*AW +: AW];
   endfunction

   // Lane i carries pc = base + 4*i, instr = pc ^ 0xDEAD0000.
   task automatic cyc(input int pn, input logic [31:0] base, input int pp,
                      input logic st = 1'b0, input logic fl = 1'b0);
      push_cnt = 3'(pn);
      pop_cnt  = 3'(pp);
      stallD   = st;
      flush    = fl;
      for (int i = 0; i < 4; i++) begin
         push_pc[i*AW +: AW]    = base + 32'(4*i);
         push_instr[i*IW +: IW] = (base + 32'(4*i)) ^ 32'hDEAD0000;
      end
      @(posedge clk);
      #1;
      push_cnt = '0;
      pop_cnt  = '0;
      stallD   = 1'b0;
      flush    = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_in_count", 64'(count), 64'd0);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_ready", 64'(push_ready), 64'd1);
      chk("rst_ovf", 64'(overflow_err), 64'd0);
      chk("rst_pc", 64'(out_pc), 64'h0);

      // Push 4, visible next cycle.
      cyc(4, 32'h100, 0);
      chk("p4_valid", 64'(out_valid), 64'hF);
      chk("p4_pc0", 64'(lpc(0)), 64'h100);
      chk("p4_pc3", 64'(lpc(3)), 64'h10C);
      chk("p4_instr3", 64'(out_instr[3*IW +: IW]), 64'hDEAD010C);
      chk("p4_count", 64'(count), 64'd4);

      // Fill to 13 and check refusal.
      cyc(4, 32'h110, 0);
      cyc(4, 32'h120, 0);
      cyc(1, 32'h130, 0);
      chk("c13_count", 64'(count), 64'd13);
      chk("c13_ready", 64'(push_ready), 64'd0);
      cyc(4, 32'h200, 0);
      chk("refuse_count", 64'(count), 64'd13);
      chk("refuse_ovf", 64'(overflow_err), 64'd1);
      chk("refuse_pc0", 64'(lpc(0)), 64'h100);
      cyc(0, 32'h0, 4);
      chk("pop4_count", 64'(count), 64'd9);
      chk("pop4_ready", 64'(push_ready), 64'd1);
      chk("pop4_pc0", 64'(lpc(0)), 64'h110);

      // head=4,tail=13 -> push 1 pop 4 -> head=8,tail=14,count=6.
      cyc(1, 32'h300, 4);
      chk("pp_count", 64'(count), 64'd6);
      chk("pp_pc0", 64'(lpc(0)), 64'h120);

      // Stalled pop ignored, push of 2 still lands.
      cyc(2, 32'h400, 4, 1'b1);
      chk("stall_count", 64'(count), 64'd8);
      chk("stall_pc0", 64'(lpc(0)), 64'h120);
      cyc(0, 32'h0, 4);
      chk("unstall_count", 64'(count), 64'd4);
      chk("unstall_pc0", 64'(lpc(0)), 64'h130);
      chk("unstall_pc2", 64'(lpc(2)), 64'h400);
      chk("unstall_pc3", 64'(lpc(3)), 64'h404);

      // Build count=10, then flush with concurrent push/pop.
      cyc(4, 32'h500, 0);
      cyc(2, 32'h520, 0);
      chk("pre_flush_count", 64'(count), 64'd10);
      cyc(4, 32'h540, 2, 1'b0, 1'b1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'h0);
      chk("flush_ready", 64'(push_ready), 64'd1);
      chk("flush_ovf_kept", 64'(overflow_err), 64'd1);
      cyc(4, 32'h600, 0);
      chk("post_flush_pc0", 64'(lpc(0)), 64'h600);
      chk("post_flush_count", 64'(count), 64'd4);

      // Walk head/tail to 14; push_cnt=6 behaves as 4, pop beyond count clamps.
      cyc(6, 32'h700, 4);
      chk("pc6_count", 64'(count), 64'd4);
      chk("pc6_pc3", 64'(lpc(3)), 64'h70C);
      cyc(4, 32'h710, 4);
      cyc(2, 32'h720, 4);
      chk("w_count2", 64'(count), 64'd2);
      cyc(0, 32'h0, 4);
      chk("clamp_count", 64'(count), 64'd0);
      cyc(0, 32'h0, 4);
      chk("empty_pop_count", 64'(count), 64'd0);
      chk("empty_valid", 64'(out_valid), 64'h0);

      // Wrap: entries at 14,15,0,1.
      cyc(4, 32'h800, 0);
      chk("wrap_count", 64'(count), 64'd4);
      chk("wrap_pc1", 64'(lpc(1)), 64'h804);
      chk("wrap_pc2", 64'(lpc(2)), 64'h808);
      chk("wrap_pc3", 64'(lpc(3)), 64'h80C);
      cyc(0, 32'h0, 3);
      chk("wrap_pop_valid", 64'(out_valid), 64'h1);
      chk("wrap_pop_pc0", 64'(lpc(0)), 64'h80C);
      chk("wrap_pop_pc1", 64'(lpc(1)), 64'h0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
